// File: rtl/ex_trap_ctrl_pkg.sv
// Shared definitions for the external-interrupt aggregator: register map,
// FSM encoding and AXI response codes.
package ex_trap_ctrl_pkg;

   localparam logic [7:0] ETI_IE        = 8'h00;
   localparam logic [7:0] ETI_MODE      = 8'h04;
   localparam logic [7:0] ETI_PEND      = 8'h08;
   localparam logic [7:0] ETI_CLAIM     = 8'h0C;
   localparam logic [7:0] ETI_COMPLETE  = 8'h10;
   localparam logic [7:0] ETI_THRESH    = 8'h14;
   localparam logic [7:0] ETI_PRIO_BASE = 8'h40;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } eti_state_e;

endpackage

// File: rtl/eti_arb.sv
// Combinational priority arbiter: highest priority among eligible sources,
// ties resolved towards the lowest index.
module eti_arb #(
   parameter int N  = 8,
   parameter int PW = 3
) (
   input  logic [N-1:0][PW-1:0] i_prio,
   input  logic [N-1:0]         i_elig,
   output logic [4:0]           o_id,
   output logic                 o_any
);

   logic [PW-1:0] w_best;

   // Strict '>' keeps the earlier (lower) index on equal priority.
   always_comb begin
      o_id   = '0;
      o_any  = 1'b0;
      w_best = '0;
      for (int i = 0; i < N; i++) begin
         if (i_elig[i] && (!o_any || (i_prio[i] > w_best))) begin
            o_any  = 1'b1;
            o_id   = 5'(i);
            w_best = i_prio[i];
         end
      end
   end

endmodule

// File: rtl/ex_trap_ctrl.sv
// External-interrupt aggregator: synchronised, prioritised sources with an
// AXI4-Lite register file, feeding one outstanding trap request to the core.
module ex_trap_ctrl
   import ex_trap_ctrl_pkg::*;
#(
   parameter int IRQ_NUM     = 8,
   parameter int PRIO_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IRQ_NUM-1:0] irq_i,
   output logic               ex_trap_valid_o,
   input  logic               ex_trap_ready_i,
   output logic [4:0]         ex_trap_id_o,
   input  logic [31:0]        eti_axi_awaddr,
   input  logic [2:0]         eti_axi_awprot,
   input  logic               eti_axi_awvalid,
   output logic               eti_axi_awready,
   input  logic [31:0]        eti_axi_wdata,
   input  logic [3:0]         eti_axi_wstrb,
   input  logic               eti_axi_wvalid,
   output logic               eti_axi_wready,
   output logic [1:0]         eti_axi_bresp,
   output logic               eti_axi_bvalid,
   input  logic               eti_axi_bready,
   input  logic [31:0]        eti_axi_araddr,
   input  logic [2:0]         eti_axi_arprot,
   input  logic               eti_axi_arvalid,
   output logic               eti_axi_arready,
   output logic [31:0]        eti_axi_rdata,
   output logic [1:0]         eti_axi_rresp,
   output logic               eti_axi_rvalid,
   input  logic               eti_axi_rready
);

   logic [SYNC_STAGES-1:0][IRQ_NUM-1:0] r_sync;
   logic [IRQ_NUM-1:0]              r_sync_q;
   logic [IRQ_NUM-1:0]              r_ie, r_mode, r_pend;
   logic [IRQ_NUM-1:0][PRIO_W-1:0]  r_prio;
   logic [PRIO_W-1:0]               r_thresh;
   logic [4:0]                      r_act_id;
   eti_state_e                      r_state, w_state_nxt;
   logic                            r_bvalid, r_rvalid;
   logic [1:0]                      r_bresp, r_rresp;
   logic [31:0]                     r_rdata;

   logic [IRQ_NUM-1:0] w_sync, w_rise, w_pend_clr, w_elig, w_wr_prio_sel;
   logic [7:0]         w_wr_off, w_rd_off;
   logic               w_wr_acc, w_wr_en, w_wr_map, w_rd_acc, w_rd_err;
   logic [31:0]        w_rd_data;
   logic [4:0]         w_arb_id;
   logic               w_arb_any, w_claim, w_complete;
   logic               w_unused;

   assign w_unused = ^{eti_axi_awprot, eti_axi_arprot, eti_axi_awaddr[31:8], eti_axi_awaddr[1:0],
                       eti_axi_araddr[31:8], eti_axi_araddr[1:0], eti_axi_wstrb[3:1],
                       eti_axi_wdata[31:5]};

   // ---------------- source path ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= '0;
         r_sync_q <= '0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], irq_i};
         r_sync_q <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_sync_q;

   assign w_claim = (r_state == ST_REQ) && ex_trap_ready_i;

   always_comb begin
      w_pend_clr = '0;
      for (int i = 0; i < IRQ_NUM; i++)
         w_pend_clr[i] = (w_wr_en && (w_wr_off == ETI_PEND) && eti_axi_wdata[i]) ||
                         (w_claim && (r_act_id == 5'(i)));
   end

   // Level bits track the synchronised input; edge bits latch, with set beating clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         for (int i = 0; i < IRQ_NUM; i++) begin
            if (!r_mode[i])        r_pend[i] <= w_sync[i];
            else if (w_rise[i])    r_pend[i] <= 1'b1;
            else if (w_pend_clr[i]) r_pend[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < IRQ_NUM; i++)
         w_elig[i] = r_pend[i] && r_ie[i] && (r_prio[i] > r_thresh);
   end

   eti_arb #(.N(IRQ_NUM), .PW(PRIO_W)) u_arb (
      .i_prio (r_prio),
      .i_elig (w_elig),
      .o_id   (w_arb_id),
      .o_any  (w_arb_any)
   );

   // ---------------- trap FSM ----------------
   assign w_complete = w_wr_en && (w_wr_off == ETI_COMPLETE) && (eti_axi_wdata[4:0] == r_act_id);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_act_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_arb_any) r_act_id <= w_arb_id;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      ex_trap_valid_o = 1'b0;
      ex_trap_id_o    = '0;
      case (r_state)
         ST_IDLE:    if (w_arb_any) w_state_nxt = ST_REQ;
         ST_REQ: begin
            ex_trap_valid_o = 1'b1;
            ex_trap_id_o    = r_act_id;
            if (ex_trap_ready_i) w_state_nxt = ST_SERVICE;
         end
         ST_SERVICE: if (w_complete) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- AXI write ----------------
   assign w_wr_off = {eti_axi_awaddr[7:2], 2'b00};
   assign w_wr_acc = eti_axi_awvalid && eti_axi_wvalid && !r_bvalid;
   assign w_wr_en  = w_wr_acc && eti_axi_wstrb[0];
   assign eti_axi_awready = w_wr_acc;
   assign eti_axi_wready  = w_wr_acc;

   always_comb begin
      w_wr_prio_sel = '0;
      for (int i = 0; i < IRQ_NUM; i++)
         w_wr_prio_sel[i] = (w_wr_off == ETI_PRIO_BASE + 8'(4*i));
      w_wr_map = (|w_wr_prio_sel) || (w_wr_off == ETI_IE) || (w_wr_off == ETI_MODE) ||
                 (w_wr_off == ETI_PEND) || (w_wr_off == ETI_CLAIM) ||
                 (w_wr_off == ETI_COMPLETE) || (w_wr_off == ETI_THRESH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ie     <= '0;
         r_mode   <= '0;
         r_thresh <= '0;
         r_prio   <= '0;
         r_bvalid <= 1'b0;
         r_bresp  <= AXI_OKAY;
      end else begin
         if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_map ? AXI_OKAY : AXI_SLVERR;
         end else if (eti_axi_bready) begin
            r_bvalid <= 1'b0;
         end
         if (w_wr_en) begin
            if (w_wr_off == ETI_IE)     r_ie     <= eti_axi_wdata[IRQ_NUM-1:0];
            if (w_wr_off == ETI_MODE)   r_mode   <= eti_axi_wdata[IRQ_NUM-1:0];
            if (w_wr_off == ETI_THRESH) r_thresh <= eti_axi_wdata[PRIO_W-1:0];
            for (int i = 0; i < IRQ_NUM; i++)
               if (w_wr_prio_sel[i]) r_prio[i] <= eti_axi_wdata[PRIO_W-1:0];
         end
      end
   end

   assign eti_axi_bvalid = r_bvalid;
   assign eti_axi_bresp  = r_bresp;

   // ---------------- AXI read ----------------
   assign w_rd_off = {eti_axi_araddr[7:2], 2'b00};
   assign w_rd_acc = eti_axi_arvalid && !r_rvalid;
   assign eti_axi_arready = w_rd_acc;

   always_comb begin
      w_rd_data = '0;
      w_rd_err  = 1'b0;
      case (w_rd_off)
         ETI_IE:       w_rd_data[IRQ_NUM-1:0] = r_ie;
         ETI_MODE:     w_rd_data[IRQ_NUM-1:0] = r_mode;
         ETI_PEND:     w_rd_data[IRQ_NUM-1:0] = r_pend;
         ETI_CLAIM:    w_rd_data[4:0]         = r_act_id;
         ETI_COMPLETE: w_rd_data              = '0;
         ETI_THRESH:   w_rd_data[PRIO_W-1:0]  = r_thresh;
         default: begin
            w_rd_err = 1'b1;
            for (int i = 0; i < IRQ_NUM; i++) begin
               if (w_rd_off == ETI_PRIO_BASE + 8'(4*i)) begin
                  w_rd_err              = 1'b0;
                  w_rd_data[PRIO_W-1:0] = r_prio[i];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= AXI_OKAY;
      end else if (w_rd_acc) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rd_err ? AXI_SLVERR : AXI_OKAY;
      end else if (eti_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   assign eti_axi_rvalid = r_rvalid;
   assign eti_axi_rdata  = r_rdata;
   assign eti_axi_rresp  = r_rresp;

endmodule

// File: tb/tb_ex_trap_ctrl.sv
// Scoreboard bench for ex_trap_ctrl: stimulus pushes expected read data, write
// responses and trap ids; a monitor pops them at each DUT handshake.
module tb_ex_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  irq;
   logic        trap_valid, trap_ready;
   logic [4:0]  trap_id;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   ex_trap_ctrl #(.IRQ_NUM(8), .PRIO_W(3), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq),
      .ex_trap_valid_o(trap_valid), .ex_trap_ready_i(trap_ready), .ex_trap_id_o(trap_id),
      .eti_axi_awaddr(awaddr), .eti_axi_awprot(3'b000), .eti_axi_awvalid(awvalid),
      .eti_axi_awready(awready), .eti_axi_wdata(wdata), .eti_axi_wstrb(wstrb),
      .eti_axi_wvalid(wvalid), .eti_axi_wready(wready), .eti_axi_bresp(bresp),
      .eti_axi_bvalid(bvalid), .eti_axi_bready(bready), .eti_axi_araddr(araddr),
      .eti_axi_arprot(3'b000), .eti_axi_arvalid(arvalid), .eti_axi_arready(arready),
      .eti_axi_rdata(rdata), .eti_axi_rresp(rresp), .eti_axi_rvalid(rvalid),
      .eti_axi_rready(rready)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   rd_exp_t    q_rd[$];
   logic [1:0] q_wr[$];
   logic [4:0] q_trap[$];
   int         n_chk = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_wr(input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s = 4'hF, input logic [1:0] er = 2'b00);
      int t;
      q_wr.push_back(er);
      awaddr = {24'h0, a}; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      t = 0;
      while (!awready && t < 50) begin tick(); t++; end
      if (!awready) check("wr_accept_timeout", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
   endtask

   task automatic axi_rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] er = 2'b00);
      int      t;
      rd_exp_t e;
      e.data = d; e.resp = er;
      q_rd.push_back(e);
      araddr = {24'h0, a}; arvalid = 1'b1;
      #1;
      t = 0;
      while (!arready && t < 50) begin tick(); t++; end
      if (!arready) check("rd_accept_timeout", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      tick();
   endtask

   task automatic wait_valid(input string name);
      int t = 0;
      while (!trap_valid && t < 50) begin tick(); t++; end
      check(name, 32'(trap_valid), 32'd1);
   endtask

   task automatic take_trap(input logic [4:0] id);
      q_trap.push_back(id);
      wait_valid("trap_valid_wait");
      trap_ready = 1'b1;
      tick();
      trap_ready = 1'b0;
   endtask

   // Monitor: every handshake seen at the falling edge consumes one expectation.
   initial begin
      forever begin
         rd_exp_t e;
         @(negedge clk);
         if (rvalid && rready) begin
            if (q_rd.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL rd_unexpected: got data 0x%0h, expected no response", rdata);
            end else begin
               e = q_rd.pop_front();
               check("rdata", rdata, e.data);
               check("rresp", 32'(rresp), 32'(e.resp));
            end
         end
         if (bvalid && bready) begin
            if (q_wr.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL wr_unexpected: got bresp %0d, expected no response", bresp);
            end else check("bresp", 32'(bresp), 32'(q_wr.pop_front()));
         end
         if (trap_valid && trap_ready) begin
            if (q_trap.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL trap_unexpected: got id %0d, expected no trap", trap_id);
            end else check("trap_id", 32'(trap_id), 32'(q_trap.pop_front()));
         end
      end
   end

   initial begin
      rst_n = 1'b0; irq = '0; trap_ready = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b1;
      #3;
      check("rst_outputs", {26'h0, trap_valid, bvalid, rvalid, awready, arready, wready},
            32'h0);
      check("rst_id", 32'(trap_id), 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick();
      axi_rd(8'h00, 32'h0);
      axi_rd(8'h08, 32'h0);

      // Two level sources, priority picks 2 then 0.
      axi_wr(8'h00, 32'h05);
      axi_wr(8'h40, 32'h1);
      axi_wr(8'h48, 32'h3);
      axi_wr(8'h14, 32'h0);
      irq = 8'h05;
      tick(3);
      check("latency_pre", 32'(trap_valid), 32'd0);
      tick();
      check("latency_valid", 32'(trap_valid), 32'd1);
      check("latency_id", 32'(trap_id), 32'd2);
      take_trap(5'd2);
      axi_rd(8'h0C, 32'h2);
      irq = 8'h01;
      tick(6);
      check("service_no_req", 32'(trap_valid), 32'd0);
      axi_wr(8'h10, 32'h2);
      take_trap(5'd0);
      irq = 8'h00;
      tick(6);
      axi_wr(8'h10, 32'h0);
      tick(6);
      check("idle_after_t1", 32'(trap_valid), 32'd0);

      // Edge source 3.
      axi_wr(8'h04, 32'h08);
      axi_wr(8'h00, 32'h08);
      axi_wr(8'h4C, 32'h2);
      irq = 8'h08; tick(); irq = 8'h00;
      tick(6);
      axi_rd(8'h08, 32'h08);
      take_trap(5'd3);
      axi_rd(8'h08, 32'h00);
      irq = 8'h08; tick(); irq = 8'h00;
      tick(6);
      axi_rd(8'h08, 32'h08);
      check("edge_service_no_req", 32'(trap_valid), 32'd0);
      axi_wr(8'h10, 32'h3);
      take_trap(5'd3);
      irq = 8'h08; tick(); irq = 8'h00;
      tick(6);
      axi_wr(8'h08, 32'h08);
      axi_rd(8'h08, 32'h00);
      axi_wr(8'h10, 32'h3);
      tick(6);
      check("edge_w1c_no_req", 32'(trap_valid), 32'd0);
      axi_wr(8'h04, 32'h00);

      // Priority tie between 1 and 4.
      axi_wr(8'h44, 32'h5);
      axi_wr(8'h50, 32'h5);
      axi_wr(8'h00, 32'h12);
      irq = 8'h12;
      take_trap(5'd1);
      irq = 8'h10;
      tick(6);
      axi_wr(8'h10, 32'h1);
      take_trap(5'd4);
      irq = 8'h00;
      tick(6);
      axi_wr(8'h10, 32'h4);
      tick(6);
      check("idle_after_tie", 32'(trap_valid), 32'd0);

      // Threshold gating, then a request held through source drop and disable.
      axi_wr(8'h00, 32'h01);
      axi_wr(8'h40, 32'h3);
      axi_wr(8'h14, 32'h3);
      irq = 8'h01;
      tick(8);
      check("thresh_block", 32'(trap_valid), 32'd0);
      axi_wr(8'h14, 32'h2);
      wait_valid("thresh_release");
      irq = 8'h00;
      axi_wr(8'h00, 32'h00);
      tick(6);
      check("req_hold_valid", 32'(trap_valid), 32'd1);
      check("req_hold_id", 32'(trap_id), 32'd0);
      take_trap(5'd0);
      axi_wr(8'h00, 32'h01);
      irq = 8'h01;
      tick(6);
      check("service_hold", 32'(trap_valid), 32'd0);
      axi_wr(8'h10, 32'h7);
      tick(6);
      check("wrong_complete", 32'(trap_valid), 32'd0);
      axi_wr(8'h10, 32'h0);
      take_trap(5'd0);
      irq = 8'h00;
      tick(6);
      axi_wr(8'h10, 32'h0);

      // AXI register-file corner cases.
      axi_rd(8'h30, 32'h0, 2'b10);
      axi_wr(8'h30, 32'h1, 4'hF, 2'b10);
      axi_wr(8'h00, 32'hFF, 4'h0);
      axi_rd(8'h00, 32'h01);
      axi_rd(8'h48, 32'h3);
      axi_rd(8'h14, 32'h2);
      axi_rd(8'h60, 32'h0, 2'b10);
      axi_wr(8'h44, 32'hFF);
      axi_rd(8'h44, 32'h7);
      axi_wr(8'h00, 32'hFFFF_FFFF);
      axi_rd(8'h00, 32'hFF);
      axi_wr(8'h00, 32'h0);

      // Write response back-pressure.
      bready = 1'b0;
      axi_wr(8'h14, 32'h0);
      q_wr.push_back(2'b00);
      awaddr = 32'h14; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_bvalid", 32'(bvalid), 32'd1);
         check("bp_awready", 32'(awready), 32'd0);
      end
      bready = 1'b1;
      begin
         int t = 0;
         #1;
         while (!awready && t < 20) begin tick(); t++; end
         check("bp_release", 32'(awready), 32'd1);
      end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      axi_rd(8'h14, 32'h1);

      // Reset while a request is pending.
      axi_wr(8'h14, 32'h0);
      axi_wr(8'h00, 32'h01);
      irq = 8'h01;
      wait_valid("pre_reset_valid");
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(trap_valid), 32'd0);
      irq = 8'h00;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      axi_rd(8'h00, 32'h0);
      tick(6);
      check("post_reset_idle", 32'(trap_valid), 32'd0);

      tick(3);
      check("scoreboard_drained", 32'(q_rd.size() + q_wr.size() + q_trap.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
